// File: rtl/z_core_mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// z_core_mem_arbiter_if : simple single-pulse memory request/response bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface z_core_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  req;
  logic                  wen;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  busy;

  modport master (
    output req, wen, addr, wdata, wstrb,
    input  rdata, ready, busy
  );

  modport slave (
    input  req, wen, addr, wdata, wstrb,
    output rdata, ready, busy
  );
endinterface
`default_nettype wire

// File: rtl/z_core_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// z_core_mem_arbiter : two requesters share one downstream memory port
// Rev 1.0
// ---------------------------------------------------------------------------
module z_core_mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  z_core_mem_arbiter_if.slave  s0_if,
  z_core_mem_arbiter_if.slave  s1_if,
  z_core_mem_arbiter_if.master m_if
);

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ISSUE = 3'b010,
    WAIT  = 3'b100
  } state_e;

  state_e                          state_q;
  logic [1:0]                      pend_q;
  logic [1:0]                      wen_q;
  logic [1:0][ADDR_WIDTH-1:0]      addr_q;
  logic [1:0][DATA_WIDTH-1:0]      wdata_q;
  logic [1:0][STRB_WIDTH-1:0]      wstrb_q;
  logic                            owner_q;
  logic                            last_grant_q;

  logic                            m_req_q;
  logic                            m_wen_q;
  logic [ADDR_WIDTH-1:0]           m_addr_q;
  logic [DATA_WIDTH-1:0]           m_wdata_q;
  logic [STRB_WIDTH-1:0]           m_wstrb_q;
  logic [1:0][DATA_WIDTH-1:0]      rdata_q;
  logic [1:0]                      ready_q;

  logic                            grant_d;

  logic [1:0]                      s_req;
  logic [1:0]                      s_wen;
  logic [1:0][ADDR_WIDTH-1:0]      s_addr;
  logic [1:0][DATA_WIDTH-1:0]      s_wdata;
  logic [1:0][STRB_WIDTH-1:0]      s_wstrb;

  assign s_req   = {s1_if.req,   s0_if.req};
  assign s_wen   = {s1_if.wen,   s0_if.wen};
  assign s_addr  = {s1_if.addr,  s0_if.addr};
  assign s_wdata = {s1_if.wdata, s0_if.wdata};
  assign s_wstrb = {s1_if.wstrb, s0_if.wstrb};

  // On contention the port that did not complete last wins (round robin),
  // otherwise port 0 always wins.
  always_comb begin
    grant_d = pend_q[1] & ~pend_q[0];
    if (&pend_q) begin
      grant_d = ROUND_ROBIN ? ~last_grant_q : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      wen_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m_req_q      <= 1'b0;
      m_wen_q      <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
      rdata_q      <= '0;
      ready_q      <= '0;
    end else begin
      ready_q <= '0;

      for (int n = 0; n < 2; n++) begin
        if (s_req[n] && !pend_q[n]) begin
          pend_q[n]  <= 1'b1;
          wen_q[n]   <= s_wen[n];
          addr_q[n]  <= s_addr[n];
          wdata_q[n] <= s_wdata[n];
          wstrb_q[n] <= s_wstrb[n];
        end
      end

      case (state_q)
        IDLE: begin
          if (|pend_q && !m_if.busy) begin
            owner_q   <= grant_d;
            m_req_q   <= 1'b1;
            m_wen_q   <= wen_q[grant_d];
            m_addr_q  <= addr_q[grant_d];
            m_wdata_q <= wdata_q[grant_d];
            m_wstrb_q <= wstrb_q[grant_d];
            state_q   <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (state_q == ISSUE) begin
            m_req_q <= 1'b0;
            state_q <= WAIT;
          end
          // A completion in the issue cycle itself is accepted as well.
          if (m_if.ready) begin
            rdata_q[owner_q] <= m_if.rdata;
            ready_q[owner_q] <= 1'b1;
            pend_q[owner_q]  <= 1'b0;
            last_grant_q     <= owner_q;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_if.req    = m_req_q;
  assign m_if.wen    = m_wen_q;
  assign m_if.addr   = m_addr_q;
  assign m_if.wdata  = m_wdata_q;
  assign m_if.wstrb  = m_wstrb_q;

  assign s0_if.rdata = rdata_q[0];
  assign s0_if.ready = ready_q[0];
  assign s0_if.busy  = pend_q[0];
  assign s1_if.rdata = rdata_q[1];
  assign s1_if.ready = ready_q[1];
  assign s1_if.busy  = pend_q[1];

endmodule
`default_nettype wire

// File: tb/tb_z_core_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_z_core_mem_arbiter : randomized and directed bench with reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_z_core_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  z_core_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) s0 ();
  z_core_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) s1 ();
  z_core_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) m ();
  z_core_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) sb0 ();
  z_core_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) sb1 ();
  z_core_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) mb ();

  // Fixed-priority instance sees the same requester traffic.
  assign sb0.req = s0.req;  assign sb0.wen = s0.wen;  assign sb0.addr = s0.addr;
  assign sb0.wdata = s0.wdata;  assign sb0.wstrb = s0.wstrb;
  assign sb1.req = s1.req;  assign sb1.wen = s1.wen;  assign sb1.addr = s1.addr;
  assign sb1.wdata = s1.wdata;  assign sb1.wstrb = s1.wstrb;

  z_core_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst(rst), .s0_if(s0), .s1_if(s1), .m_if(m));
  z_core_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .s0_if(sb0), .s1_if(sb1), .m_if(mb));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: one pending slot per port, one transaction in flight.
  bit          mp[2] = '{0, 0};
  logic        s_wen[2];
  logic [31:0] s_addr[2], s_data[2];
  logic [3:0]  s_strb[2];
  bit          active = 0;
  bit          own = 0;
  bit          last = 1;
  bit          e_mreq = 0;
  logic        e_wen = 0;
  logic [31:0] e_addr = 0, e_wdata = 0;
  logic [3:0]  e_strb = 0;
  bit          e_rdy[2] = '{0, 0};
  logic [31:0] e_rdata[2] = '{0, 0};

  // Downstream responders
  int          rcnt = -1, rbcnt = -1;
  int          lat = 3;
  bit          rand_lat = 0;
  bit          rfixed = 0;
  logic [31:0] rval = 0, rpend_val = 0;
  bit          mbusy_drv = 0;

  // Observation logs
  logic [31:0] log_addr[$];
  logic [68:0] log_txn[$];
  int          log_cyc[$];
  logic [31:0] b_log[$];
  int          rdy_cnt[2];
  int          rdy_cyc[2];
  logic [31:0] rdy_data[2];

  task automatic clear_logs();
    log_addr.delete(); log_txn.delete(); log_cyc.delete(); b_log.delete();
    rdy_cnt[0] = 0; rdy_cnt[1] = 0; rdy_cyc[0] = -1; rdy_cyc[1] = -1;
  endtask

  task automatic model_update();
    bit op[2];
    bit rq[2];
    bit w;
    op = mp;
    rq[0] = s0.req; rq[1] = s1.req;
    e_rdy[0] = 0; e_rdy[1] = 0; e_mreq = 0;
    if (rst) begin
      mp = '{0, 0}; active = 0; last = 1; own = 0;
      e_wen = 0; e_addr = 0; e_wdata = 0; e_strb = 0; e_rdata = '{0, 0};
      return;
    end
    if (!active) begin
      if ((op[0] || op[1]) && !m.busy) begin
        if (op[0] && op[1]) w = !last;
        else w = op[1];
        own = w; active = 1; e_mreq = 1;
        e_wen = s_wen[w]; e_addr = s_addr[w]; e_wdata = s_data[w]; e_strb = s_strb[w];
      end
    end else if (m.ready) begin
      e_rdy[own] = 1; e_rdata[own] = m.rdata; mp[own] = 0; last = own; active = 0;
    end
    if (rq[0] && !op[0]) begin
      mp[0] = 1; s_wen[0] = s0.wen; s_addr[0] = s0.addr; s_data[0] = s0.wdata; s_strb[0] = s0.wstrb;
    end
    if (rq[1] && !op[1]) begin
      mp[1] = 1; s_wen[1] = s1.wen; s_addr[1] = s1.addr; s_data[1] = s1.wdata; s_strb[1] = s1.wstrb;
    end
  endtask

  // One clock cycle: drive responders, check at negedge, advance model.
  task automatic step();
    if (rcnt == 0) begin m.ready = 1; m.rdata = rpend_val; rcnt = -1; end
    else begin m.ready = 0; m.rdata = $urandom; if (rcnt > 0) rcnt--; end
    if (rbcnt == 0) begin mb.ready = 1; mb.rdata = $urandom; rbcnt = -1; end
    else begin mb.ready = 0; mb.rdata = $urandom; if (rbcnt > 0) rbcnt--; end
    m.busy = mbusy_drv;
    @(negedge clk);
    checks++;
    if (m.req !== e_mreq) begin
      errors++; $display("FAIL m_req cyc %0d: got %b expected %b", cyc, m.req, e_mreq);
    end
    checks++;
    if ({m.wen, m.addr, m.wdata, m.wstrb} !== {e_wen, e_addr, e_wdata, e_strb}) begin
      errors++; $display("FAIL m_fields cyc %0d: got %h expected %h", cyc,
                         {m.wen, m.addr, m.wdata, m.wstrb}, {e_wen, e_addr, e_wdata, e_strb});
    end
    checks++;
    if ({s0.ready, s0.busy, s0.rdata} !== {e_rdy[0], mp[0], e_rdata[0]}) begin
      errors++; $display("FAIL s0_resp cyc %0d: got %h expected %h", cyc,
                         {s0.ready, s0.busy, s0.rdata}, {e_rdy[0], mp[0], e_rdata[0]});
    end
    checks++;
    if ({s1.ready, s1.busy, s1.rdata} !== {e_rdy[1], mp[1], e_rdata[1]}) begin
      errors++; $display("FAIL s1_resp cyc %0d: got %h expected %h", cyc,
                         {s1.ready, s1.busy, s1.rdata}, {e_rdy[1], mp[1], e_rdata[1]});
    end
    if (m.req === 1'b1) begin
      if (rand_lat) lat = $urandom_range(1, 4);
      rcnt = lat - 1;
      rpend_val = rfixed ? rval : $urandom;
      log_addr.push_back(m.addr);
      log_txn.push_back({m.wen, m.addr, m.wdata, m.wstrb});
      log_cyc.push_back(cyc);
    end
    if (mb.req === 1'b1) begin
      rbcnt = 1;
      b_log.push_back(mb.addr);
    end
    if (s0.ready === 1'b1) begin rdy_cnt[0]++; rdy_cyc[0] = cyc; rdy_data[0] = s0.rdata; end
    if (s1.ready === 1'b1) begin rdy_cnt[1]++; rdy_cyc[1] = cyc; rdy_data[1] = s1.rdata; end
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    s0.req = 0;
    s1.req = 0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_req(input int n, input bit wen, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
    if (n == 0) begin s0.req = 1; s0.wen = wen; s0.addr = addr; s0.wdata = data; s0.wstrb = strb; end
    else begin s1.req = 1; s1.wen = wen; s1.addr = addr; s1.wdata = data; s1.wstrb = strb; end
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({m.req, m.wen, m.addr, m.wdata, m.wstrb} !== '0) begin
      errors++; $display("FAIL %s m_out: got %h expected 0", name, {m.req, m.wen, m.addr, m.wdata, m.wstrb});
    end
    checks++;
    if ({s0.ready, s0.busy, s0.rdata, s1.ready, s1.busy, s1.rdata} !== '0) begin
      errors++; $display("FAIL %s s_out: got %h expected 0", name,
                         {s0.ready, s0.busy, s0.rdata, s1.ready, s1.busy, s1.rdata});
    end
  endtask

  task automatic test_reset();
    rst = 1; steps(2);
    check_outputs_zero("reset");
    rst = 0;
  endtask

  task automatic test_single_read();
    int t;
    clear_logs();
    lat = 3; rand_lat = 0; rfixed = 1; rval = 32'hDEADBEEF;
    set_req(0, 0, 32'h100, $urandom, 4'h0);
    t = cyc;
    steps(14);
    checks++;
    if (log_cyc.size() != 1 || log_cyc[0] != t + 2) begin
      errors++; $display("FAIL single_mreq: got %0d pulses first at %0d, expected 1 at %0d",
                         log_cyc.size(), (log_cyc.size() > 0) ? log_cyc[0] : -1, t + 2);
    end
    checks++;
    if (log_txn.size() != 1 || log_txn[0][68:36] !== {1'b0, 32'h100}) begin
      errors++; $display("FAIL single_addr: got %h expected 0_00000100",
                         (log_txn.size() > 0) ? log_txn[0][68:36] : 33'h0);
    end
    checks++;
    if (rdy_cnt[0] != 1 || rdy_cyc[0] != t + 6 || rdy_data[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL single_ready: got cnt %0d cyc %0d data %h expected 1 %0d deadbeef",
                         rdy_cnt[0], rdy_cyc[0], rdy_data[0], t + 6);
    end
    checks++;
    if (rdy_cnt[1] != 0) begin
      errors++; $display("FAIL single_s1: got %0d s1_ready expected 0", rdy_cnt[1]);
    end
    rfixed = 0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    clear_logs();
    rand_lat = 1;
    set_req(0, 0, 32'h10, $urandom, 4'h0);
    set_req(1, 1, 32'h20, 32'h55AA55AA, 4'hF);
    steps(20);
    checks++;
    if (log_txn.size() != 2 || log_txn[0][68:36] !== {1'b0, 32'h10} ||
        log_txn[1] !== {1'b1, 32'h20, 32'h55AA55AA, 4'hF}) begin
      errors++; $display("FAIL simul_order: got %0d txns first %h second %h expected 0_00000010 then 1_00000020_55aa55aa_f",
                         log_txn.size(), (log_txn.size() > 0) ? log_txn[0] : 69'h0,
                         (log_txn.size() > 1) ? log_txn[1] : 69'h0);
    end
    checks++;
    if (rdy_cnt[0] != 1 || rdy_cnt[1] != 1) begin
      errors++; $display("FAIL simul_ready: got %0d/%0d expected 1/1", rdy_cnt[0], rdy_cnt[1]);
    end
    // A lone port-0 completion hands the next contention to port 1.
    set_req(0, 0, 32'h18, $urandom, 4'h0);
    steps(10);
    clear_logs();
    set_req(0, 0, 32'h14, $urandom, 4'h0);
    set_req(1, 0, 32'h24, $urandom, 4'h0);
    steps(20);
    checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 32'h24 || log_addr[1] !== 32'h14) begin
      errors++; $display("FAIL simul_rr: got %0d txns first %h expected 00000024 then 00000014",
                         log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 32'h0);
    end
  endtask

  task automatic test_fixed_priority();
    clear_logs();
    rand_lat = 1;
    for (int i = 0; i < 3; i++) begin
      set_req(0, 0, 32'h200 + 32'(i * 8), $urandom, 4'h0);
      set_req(1, 1, 32'h300 + 32'(i * 8), $urandom, 4'h3);
      steps(24);
    end
    checks++;
    if (b_log.size() != 6) begin
      errors++; $display("FAIL fixed_count: got %0d grants expected 6", b_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (b_log[2*i] !== 32'h200 + 32'(i * 8) || b_log[2*i+1] !== 32'h300 + 32'(i * 8)) begin
          errors++; $display("FAIL fixed_order pair %0d: got %h,%h expected %h,%h", i,
                             b_log[2*i], b_log[2*i+1], 32'h200 + 32'(i * 8), 32'h300 + 32'(i * 8));
        end
      end
    end
  endtask

  task automatic test_duplicate();
    clear_logs();
    rand_lat = 0; lat = 4;
    set_req(1, 0, 32'h30, $urandom, 4'h0);
    step();
    set_req(1, 0, 32'h40, $urandom, 4'h0);
    steps(3);
    set_req(1, 0, 32'h40, $urandom, 4'h0);
    steps(12);
    checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h30) begin
      errors++; $display("FAIL dup_issue: got %0d txns first %h expected 1 at 00000030",
                         log_addr.size(), (log_addr.size() > 0) ? log_addr[0] : 32'h0);
    end
    checks++;
    if (rdy_cnt[1] != 1) begin
      errors++; $display("FAIL dup_ready: got %0d expected 1", rdy_cnt[1]);
    end
  endtask

  task automatic test_mbusy();
    int rel;
    clear_logs();
    mbusy_drv = 1;
    set_req(0, 1, 32'h80, $urandom, 4'hC);
    steps(6);
    checks++;
    if (log_cyc.size() != 0 || s0.busy !== 1'b1) begin
      errors++; $display("FAIL mbusy_hold: got %0d grants busy %b expected 0 grants busy 1",
                         log_cyc.size(), s0.busy);
    end
    mbusy_drv = 0;
    rel = cyc;
    steps(12);
    checks++;
    if (log_cyc.size() != 1 || log_cyc[0] != rel + 1) begin
      errors++; $display("FAIL mbusy_release: got %0d grants first at %0d expected 1 at %0d",
                         log_cyc.size(), (log_cyc.size() > 0) ? log_cyc[0] : -1, rel + 1);
    end
  endtask

  task automatic test_reset_wait();
    int n;
    clear_logs();
    lat = 4; rand_lat = 0;
    set_req(0, 1, 32'h500, $urandom, 4'hF);
    n = 0;
    while (log_cyc.size() == 0 && n < 10) begin step(); n++; end
    checks++;
    if (log_cyc.size() == 0) begin
      errors++; $display("FAIL rstwait_issue: got no m_req within 10 cycles expected one");
    end
    step();
    rst = 1; step(); rst = 0;
    check_outputs_zero("rstwait");
    steps(6);
    checks++;
    if (rdy_cnt[0] != 0) begin
      errors++; $display("FAIL rstwait_late: got %0d s0_ready expected 0", rdy_cnt[0]);
    end
    set_req(1, 0, 32'h600, $urandom, 4'h0);
    steps(12);
    checks++;
    if (rdy_cnt[1] != 1) begin
      errors++; $display("FAIL rstwait_next: got %0d s1_ready expected 1", rdy_cnt[1]);
    end
  endtask

  task automatic test_random();
    rand_lat = 1;
    for (int i = 0; i < 800; i++) begin
      mbusy_drv = ($urandom_range(0, 3) == 0);
      s0.wen = $urandom; s0.addr = $urandom; s0.wdata = $urandom; s0.wstrb = 4'($urandom);
      s1.wen = $urandom; s1.addr = $urandom; s1.wdata = $urandom; s1.wstrb = 4'($urandom);
      s0.req = ($urandom_range(0, 9) < 3);
      s1.req = ($urandom_range(0, 9) < 3);
      step();
    end
    mbusy_drv = 0;
    steps(20);
  endtask

  initial begin
    rst = 1;
    s0.req = 0; s0.wen = 0; s0.addr = 0; s0.wdata = 0; s0.wstrb = 0;
    s1.req = 0; s1.wen = 0; s1.addr = 0; s1.wdata = 0; s1.wstrb = 0;
    m.ready = 0; m.rdata = 0; m.busy = 0;
    mb.ready = 0; mb.rdata = 0; mb.busy = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fixed_priority();
    test_duplicate();
    test_mbusy();
    test_reset_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
